lcd_phrase_writer: RTL
======================

Name: lcd_phrase_writer

Overview:
- Reads the 32-character phrase ROM sequentially and writes it to an HD44780-compatible 16x2 character LCD over the 8-bit parallel bus, in write-only mode.
- Characters 0–15 go to line 1 and characters 16–31 go to line 2.
- The block performs the LCD power-up/init sequence once after reset, then refreshes the display automatically. It refreshes again on each `start` request.
- It is the consumer of the phrase ROMs, which have a registered read with 1-cycle latency. Menu logic selects which ROM drives `rom_data`.

Parameters:
- POWERUP_CYCLES, 750000, idle wait after reset before the first command (15 ms at 50 MHz).
- ENABLE_CYCLES, 25, `lcd_en` high time per transfer (0.5 us).
- CMD_WAIT_CYCLES, 2000, wait after `lcd_en` falls for normal commands and characters (40 us).
- CLEAR_WAIT_CYCLES, 82000, wait after `lcd_en` falls for the clear command 0x01 (1.64 ms).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  refresh request; sampled only in IDLE.
- rom_data  in  8  ROM output; valid 1 cycle after `rom_addr`.
- rom_addr  out  5  ROM address.
- lcd_data  out  8  LCD DB7..DB0.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_rw  out  1  tied 0 (write-only).
- lcd_en  out  1  LCD enable strobe.
- busy  out  1  1 in every state except IDLE.
- done  out  1  1-cycle pulse when a refresh completes.

Behaviour:

Reset (`reset` low, asynchronous):
- State goes to POWERUP and all counters clear.
- Output reset values: `rom_addr`=0, `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, `busy`=1, `done`=0.
- Reset asserted mid-operation aborts immediately. After release the full POWERUP and init sequence reruns.

POWERUP:
- Waits POWERUP_CYCLES, then enters INIT.

Transfer primitive (used for every command and character):
- SETUP, 1 cycle:
  - `lcd_data` and `lcd_rs` are registered.
  - `lcd_en` stays 0.
- PULSE, ENABLE_CYCLES cycles:
  - `lcd_en`=1.
  - `lcd_data` and `lcd_rs` are held stable.
- WAIT, CMD_WAIT_CYCLES cycles (CLEAR_WAIT_CYCLES if the command is 0x01):
  - `lcd_en`=0.
  - `lcd_data` and `lcd_rs` stay held.
- Commands: cost 1+E+W cycles, `lcd_rs`=0.

INIT:
- Sends commands in order with `lcd_rs`=0: 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear).
- Then enters REFRESH without waiting for `start`.

REFRESH:
1. Command 0x80 (DDRAM address 0, line 1).
2. Characters at addresses 0..15.
3. Command 0xC0 (DDRAM address 0x40, line 2).
4. Characters at addresses 16..31.

Character transfer:
- FETCH, 1 cycle: `rom_addr` already equals the index; this cycle covers ROM latency.
- SETUP: `lcd_data` <= `rom_data`, `lcd_rs`=1.
- Then PULSE and WAIT as in the transfer primitive.
- Total cost is 2+E+W cycles.
- `rom_addr` increments by 1 on entering WAIT of each character. It stays stable during FETCH, SETUP and PULSE.
- After character 31, `rom_addr` wraps to 0 (5-bit natural wrap).

End of refresh:
- After the WAIT of character 31, `done`=1 for exactly 1 cycle and the state goes to IDLE.
- `done` pulses after the auto-refresh following init as well as after `start`-triggered refreshes.

IDLE:
- `busy`=0, `lcd_en`=0, `rom_addr`=0.
- `start`=1 moves to REFRESH on the next edge; `busy`=1 from that edge.
- `start` while `busy`=1 is ignored (not queued).
- `start` held high continuously causes back-to-back refreshes: one IDLE cycle between them.

Other rules:
- `lcd_en` never rises in the same cycle that `lcd_data` or `lcd_rs` changes.
- `rom_data` is sampled only in SETUP of a character transfer. Changing the selected ROM mid-refresh affects only later characters.
- All counters must be wide enough for the largest parameter.

Test Plan:
Parameters for all scenarios: POWERUP=10, ENABLE=2, CMD_WAIT=4, CLEAR_WAIT=8; ROM model with 1-cycle latency holding the DEFINIR PRINC phrase.
1. Reset release, count cycles:
   - `lcd_en` first rises 11 cycles after release, with `lcd_data`=0x38, `lcd_rs`=0.
   - The init bytes are 0x38, 0x0C, 0x06, 0x01.
   - The gap after the 0x01 `lcd_en` fall is 8 cycles; after the others it is 4.
2. Auto-refresh capture of every `lcd_en` rising edge:
   - Exactly 0x80, then "DEFINIR PRINC:  " with `rs`=1, then 0xC0, then "P:XY  S:XY  A:XY".
   - `done` pulses once, then `busy`=0.
3. In IDLE, pulse `start` for 1 cycle:
   - `busy`=1 on the next cycle.
   - Identical 34-transfer sequence with 2+2+4=8 cycles per character.
   - `done` pulses once; `rom_addr`=0 in IDLE.
4. Pulse `start` repeatedly during a refresh:
   - No extra refresh.
   - Exactly one `done` pulse.
   - Transfer count stays 34.
5. Assert `reset` low during character 20's PULSE:
   - `lcd_en`=0, `rom_addr`=0, `busy`=1 immediately, without waiting for a clock edge.
   - After release the full init sequence (0x38 first) replays.
6. Protocol checker over the whole run:
   - `lcd_data` and `lcd_rs` are stable whenever `lcd_en`=1.
   - `lcd_rw` is always 0.
   - Every `lcd_en` high pulse lasts exactly 2 cycles.

Source files
------------

// File: rtl/lcd_phrase_writer.sv
// lcd_phrase_writer
// Streams a 32-character phrase from a phrase ROM onto an HD44780-compatible
// 16x2 character LCD over the 8-bit write-only parallel bus. After reset it
// waits out the LCD power-up time and runs the init command sequence. It then
// refreshes both display lines once on its own, and again on every start
// request seen while idle.
//
// Every byte sent to the LCD goes through the same transfer primitive:
//   SETUP (1 cycle, bus registered, en low)
//   PULSE (ENABLE_CYCLES, en high, bus held)
//   WAIT  (CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES after 0x01, en low, bus held)
// A character transfer is preceded by a FETCH cycle that covers the ROM's
// registered-read latency.
//
// The whole job is one linear list of steps, indexed by step_q:
//   0..3   init commands 0x38, 0x0C, 0x06, 0x01
//   4      set DDRAM address 0x00 (line 1)
//   5..20  characters 0..15
//   21     set DDRAM address 0x40 (line 2)
//   22..37 characters 16..31
// A start request from IDLE re-enters the list at step 4.

module lcd_phrase_writer #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int ENABLE_CYCLES     = 25,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] rom_data,
    output logic [4:0] rom_addr,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------
    // Counter sizing: one shared cycle counter times every phase, so it is
    // sized for the longest of the four delays.
    // ------------------------------------------------------------------
    localparam int MAX_AB     = (POWERUP_CYCLES > ENABLE_CYCLES) ? POWERUP_CYCLES : ENABLE_CYCLES;
    localparam int MAX_CD     = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENABLE_LAST  = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    // Step list landmarks.
    localparam logic [5:0] STEP_INIT_FIRST = 6'd0;
    localparam logic [5:0] STEP_LINE1_CMD  = 6'd4;
    localparam logic [5:0] STEP_LINE2_CMD  = 6'd21;
    localparam logic [5:0] STEP_LAST       = 6'd37;

    // LCD command bytes.
    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_CLEAR        = 8'h01;  // clear display (slow)
    localparam logic [7:0] CMD_LINE1_ADDR   = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2_ADDR   = 8'hC0;  // DDRAM address 0x40

    typedef enum logic [2:0] {
        S_POWERUP,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Step decoding
    // ------------------------------------------------------------------

    // True for steps that carry a ROM character rather than a command.
    function automatic logic step_is_char(input logic [5:0] s);
        return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= STEP_LAST));
    endfunction

    // Command byte for a command step; characters never use this value.
    function automatic logic [7:0] step_cmd(input logic [5:0] s);
        logic [7:0] c;
        case (s)
            6'd0:           c = CMD_FUNCTION_SET;
            6'd1:           c = CMD_DISPLAY_ON;
            6'd2:           c = CMD_ENTRY_MODE;
            6'd3:           c = CMD_CLEAR;
            STEP_LINE1_CMD: c = CMD_LINE1_ADDR;
            STEP_LINE2_CMD: c = CMD_LINE2_ADDR;
            default:        c = 8'h00;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [5:0]       step_q,     step_d;
    logic [4:0]       rom_addr_q, rom_addr_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q,   lcd_rs_d;
    logic             done_q,     done_d;

    // The clear command needs the long settle time; everything else the short one.
    logic [CNT_W-1:0] wait_last;
    assign wait_last = (!lcd_rs_q && (lcd_data_q == CMD_CLEAR)) ? CLEAR_LAST : CMD_LAST;

    // State and datapath registers; reset aborts any transfer and restarts power-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_POWERUP;
            cnt_q      <= '0;
            step_q     <= STEP_INIT_FIRST;
            rom_addr_q <= '0;
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values,
            // independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            rom_addr_q <= rom_addr_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-datapath logic for the transfer sequencer.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path
        // through the case leaves one unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        rom_addr_d = rom_addr_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_POWERUP: begin
                if (cnt_q == POWERUP_LAST) begin
                    // Bus is loaded on entry to SETUP so en rises a cycle later.
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    step_d     = STEP_INIT_FIRST;
                    lcd_data_d = step_cmd(STEP_INIT_FIRST);
                    lcd_rs_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FETCH: begin
                // rom_addr has been stable for at least one edge, so the
                // registered ROM output now belongs to this character.
                state_d    = S_SETUP;
                lcd_data_d = rom_data;
                lcd_rs_d   = 1'b1;
            end

            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end

            S_PULSE: begin
                if (cnt_q == ENABLE_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    // Advance the ROM address early so the next read has the
                    // whole WAIT phase to settle; wraps to 0 after char 31.
                    if (step_is_char(step_q)) begin
                        rom_addr_d = rom_addr_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (step_q == STEP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        step_d = step_q + 6'd1;
                        if (step_is_char(step_q + 6'd1)) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d    = S_SETUP;
                            lcd_data_d = step_cmd(step_q + 6'd1);
                            lcd_rs_d   = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                rom_addr_d = '0;
                if (start) begin
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    step_d     = STEP_LINE1_CMD;
                    lcd_data_d = CMD_LINE1_ADDR;
                    lcd_rs_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_POWERUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: strobe and status come straight from the state register.
    always_comb begin
        lcd_en   = (state_q == S_PULSE);
        busy     = (state_q != S_IDLE);
        done     = done_q;
        lcd_rw   = 1'b0;
        lcd_data = lcd_data_q;
        lcd_rs   = lcd_rs_q;
        rom_addr = rom_addr_q;
    end

endmodule
